// File: rtl/metrics_pkg.sv
// Shared types and limits for the metrics counter bank.
package metrics_pkg;

    localparam int unsigned MAX_CHANNELS      = 32;
    localparam int unsigned MAX_COUNTER_WIDTH = 64;

    typedef enum logic {
        CNT_CYCLES = 1'b0,
        CNT_EVENTS = 1'b1
    } count_mode_e;

    // A channel advances when enabled and its selected source is active this cycle.
    function automatic logic count_qualified(input logic en, input count_mode_e mode,
                                             input logic evt);
        return en & ((mode == CNT_CYCLES) | evt);
    endfunction

endpackage

// File: rtl/metrics_counter_channel.sv
// One counter channel: live count, sticky overflow flag and snapshot register.
module metrics_counter_channel
    import metrics_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter bit          SATURATE      = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     mode,
    input  logic                     evt,
    input  logic                     snapshot,
    output logic [COUNTER_WIDTH-1:0] cnt,
    output logic [COUNTER_WIDTH-1:0] snap,
    output logic                     ovf
);

    localparam logic [COUNTER_WIDTH-1:0] CntOne = COUNTER_WIDTH'(1);

    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] snap_q, snap_d;
    logic                     ovf_q, ovf_d;
    logic                     inc;
    logic                     at_max;

    assign inc    = count_qualified(en, count_mode_e'(mode), evt);
    assign at_max = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (at_max) begin
                ovf_d = 1'b1;
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    // Capture uses the pre-update value, so a same-cycle clear still snapshots the old count.
    assign snap_d = snapshot ? cnt_q : snap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            snap_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cnt  = cnt_q;
    assign snap = snap_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/metrics_counter_bank.sv
// Bank of independent performance counters with a global snapshot capture.
module metrics_counter_bank
    import metrics_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter bit          SATURATE      = 1'b0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_CHANNELS-1:0]                    en,
    input  logic [NUM_CHANNELS-1:0]                    clear,
    input  logic [NUM_CHANNELS-1:0]                    mode,
    input  logic [NUM_CHANNELS-1:0]                    evt,
    input  logic                                       snapshot,
    output logic [NUM_CHANNELS-1:0][COUNTER_WIDTH-1:0] cnt,
    output logic [NUM_CHANNELS-1:0][COUNTER_WIDTH-1:0] snap,
    output logic                                       snap_valid,
    output logic [NUM_CHANNELS-1:0]                    ovf
);

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("metrics_counter_bank: NUM_CHANNELS must be within 1..32");
    end
    if (COUNTER_WIDTH < 8 || COUNTER_WIDTH > MAX_COUNTER_WIDTH) begin : g_bad_width
        $error("metrics_counter_bank: COUNTER_WIDTH must be within 8..64");
    end

    logic snap_valid_q;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        metrics_counter_channel #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .SATURATE      (SATURATE)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .clear    (clear[i]),
            .mode     (mode[i]),
            .evt      (evt[i]),
            .snapshot (snapshot),
            .cnt      (cnt[i]),
            .snap     (snap[i]),
            .ovf      (ovf[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_valid_q <= 1'b0;
        end else begin
            snap_valid_q <= snapshot;
        end
    end

    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_metrics_counter_bank.sv
// Scoreboard bench: a wrapping and a saturating 8-bit bank share stimulus and a reference model.
module tb_metrics_counter_bank;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NCH-1:0]          en = '0, clear = '0, mode = '0, evt = '0;
    logic                    snapshot = 1'b0;
    logic [NCH-1:0][W-1:0]   cnt_w, snap_w, cnt_s, snap_s;
    logic [NCH-1:0]          ovf_w, ovf_s;
    logic                    sv_w, sv_s;

    metrics_counter_bank #(.NUM_CHANNELS(NCH), .COUNTER_WIDTH(W), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode), .evt(evt),
        .snapshot(snapshot), .cnt(cnt_w), .snap(snap_w), .snap_valid(sv_w), .ovf(ovf_w)
    );

    metrics_counter_bank #(.NUM_CHANNELS(NCH), .COUNTER_WIDTH(W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode), .evt(evt),
        .snapshot(snapshot), .cnt(cnt_s), .snap(snap_s), .snap_valid(sv_s), .ovf(ovf_s)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]           tgt;
        logic [NCH-1:0][W-1:0] cnt_w, cnt_s, snap_w, snap_s;
        logic [NCH-1:0]        ovf_w, ovf_s;
        logic                  sv;
    } exp_t;

    typedef struct packed {
        logic [NCH-1:0][W-1:0] w, s;
    } snap_exp_t;

    exp_t      sb_q[$];
    snap_exp_t snq[$];

    // Reference model: index 0 = wrapping bank, 1 = saturating bank.
    int m_cnt [2][NCH];
    bit m_ovf [2][NCH];
    int m_snap[2][NCH];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH-1:0][W-1:0] pack_vals(input int d, input bit use_snap);
        logic [NCH-1:0][W-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = W'(use_snap ? m_snap[d][i] : m_cnt[d][i]);
        return r;
    endfunction

    function automatic logic [NCH-1:0] pack_ovf(input int d);
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = m_ovf[d][i];
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NCH; i++) begin
                m_cnt[d][i]  = 0;
                m_ovf[d][i]  = 1'b0;
                m_snap[d][i] = 0;
            end
        end
    endtask

    // Called just after a rising edge: drive one cycle of inputs, predict the next edge.
    task automatic step(input logic [NCH-1:0] e, input logic [NCH-1:0] c,
                        input logic [NCH-1:0] m, input logic [NCH-1:0] v, input logic s);
        exp_t      x;
        snap_exp_t sx;
        en = e; clear = c; mode = m; evt = v; snapshot = s;
        if (s) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < NCH; i++) m_snap[d][i] = m_cnt[d][i];
            sx.w = pack_vals(0, 1'b1);
            sx.s = pack_vals(1, 1'b1);
            snq.push_back(sx);
        end
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NCH; i++) begin
                if (c[i]) begin
                    m_cnt[d][i] = 0;
                    m_ovf[d][i] = 1'b0;
                end else if (e[i] && (!m[i] || v[i])) begin
                    int nxt = m_cnt[d][i] + 1;
                    if (nxt > 255) begin
                        m_ovf[d][i] = 1'b1;
                        nxt = (d == 1) ? 255 : nxt - 256;
                    end
                    m_cnt[d][i] = nxt;
                end
            end
        end
        x.tgt    = cyc + 1;
        x.cnt_w  = pack_vals(0, 1'b0);
        x.cnt_s  = pack_vals(1, 1'b0);
        x.snap_w = pack_vals(0, 1'b1);
        x.snap_s = pack_vals(1, 1'b1);
        x.ovf_w  = pack_ovf(0);
        x.ovf_s  = pack_ovf(1);
        x.sv     = s;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, '0, '0, 1'b0);
    endtask

    // Reset is raised between edges; outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        #1;
        check("sb_drained_before_reset", 64'(sb_q.size()), 64'd0);
        check("snap_drained_before_reset", 64'(snq.size()), 64'd0);
        sb_q.delete();
        snq.delete();
        rst = 1'b1;
        #1;
        check("rst_cnt_w", 64'(cnt_w), 64'd0);
        check("rst_cnt_s", 64'(cnt_s), 64'd0);
        check("rst_snap_w", 64'(snap_w), 64'd0);
        check("rst_snap_s", 64'(snap_s), 64'd0);
        check("rst_ovf", 64'({ovf_w, ovf_s}), 64'd0);
        check("rst_snap_valid", 64'({sv_w, sv_s}), 64'd0);
        en = '0; clear = '0; mode = '0; evt = '0; snapshot = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t      x;
        snap_exp_t sx;
        if (!rst && sb_q.size() > 0 && sb_q[0].tgt == cyc) begin
            x = sb_q.pop_front();
            check("cnt_wrap", 64'(cnt_w), 64'(x.cnt_w));
            check("cnt_sat", 64'(cnt_s), 64'(x.cnt_s));
            check("ovf_wrap", 64'(ovf_w), 64'(x.ovf_w));
            check("ovf_sat", 64'(ovf_s), 64'(x.ovf_s));
            check("snap_wrap_hold", 64'(snap_w), 64'(x.snap_w));
            check("snap_sat_hold", 64'(snap_s), 64'(x.snap_s));
            check("snap_valid_wrap", 64'(sv_w), 64'(x.sv));
            check("snap_valid_sat", 64'(sv_s), 64'(x.sv));
        end
        if (!rst && sv_w === 1'b1) begin
            if (snq.size() == 0) begin
                check("snap_valid_unexpected", 64'd1, 64'd0);
            end else begin
                sx = snq.pop_front();
                check("snap_capture_wrap", 64'(snap_w), 64'(sx.w));
                check("snap_capture_sat", 64'(snap_s), 64'(sx.s));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NCH-1:0] e, c, m, v;
        model_reset();
        do_reset();

        // Cycle mode on channel 0.
        for (int k = 0; k < 10; k++) step(4'b0001, '0, 4'b0000, '0, 1'b0);
        check("cyc_mode_cnt0", 64'(cnt_w[0]), 64'd10);
        check("cyc_mode_others", 64'({cnt_w[3], cnt_w[2], cnt_w[1]}), 64'd0);
        check("cyc_mode_ovf", 64'(ovf_w), 64'd0);

        // Event mode on channel 1, then disabled with extra pulses.
        for (int k = 0; k < 20; k++) begin
            v = (k == 3 || k == 9 || k == 15) ? 4'b0010 : 4'b0000;
            step(4'b0010, '0, 4'b0010, v, 1'b0);
        end
        check("evt_mode_cnt1", 64'(cnt_w[1]), 64'd3);
        for (int k = 0; k < 4; k++) step(4'b0000, '0, 4'b0010, (k[0] ? 4'b0010 : 4'b0000), 1'b0);
        check("evt_disabled_cnt1", 64'(cnt_w[1]), 64'd3);

        // Overflow: 257 then 300 counts on channel 3.
        for (int k = 0; k < 257; k++) step(4'b1000, '0, '0, '0, 1'b0);
        check("wrap_257_cnt", 64'(cnt_w[3]), 64'd1);
        check("wrap_257_ovf", 64'(ovf_w[3]), 64'd1);
        for (int k = 0; k < 43; k++) step(4'b1000, '0, '0, '0, 1'b0);
        check("sat_300_cnt", 64'(cnt_s[3]), 64'd255);
        check("sat_300_ovf", 64'(ovf_s[3]), 64'd1);
        step(4'b1000, 4'b1000, '0, '0, 1'b0);
        check("wrap_clear_cnt", 64'(cnt_w[3]), 64'd0);
        check("wrap_clear_ovf", 64'(ovf_w[3]), 64'd0);

        // Snapshot coinciding with clear on channel 0 at 42.
        step('0, 4'b0001, '0, '0, 1'b0);
        for (int k = 0; k < 42; k++) step(4'b0001, '0, '0, '0, 1'b0);
        check("pre_snap_cnt0", 64'(cnt_w[0]), 64'd42);
        step(4'b0001, 4'b0001, '0, '0, 1'b1);
        check("snap_clear_snap0", 64'(snap_w[0]), 64'd42);
        check("snap_clear_cnt0", 64'(cnt_w[0]), 64'd0);
        check("snap_clear_valid", 64'(sv_w), 64'd1);
        idle(1);
        check("snap_valid_one_cycle", 64'(sv_w), 64'd0);
        check("snap_hold", 64'(snap_w[0]), 64'd42);

        // Snapshot held for three cycles while counting.
        for (int k = 0; k < 3; k++) step(4'b0101, '0, '0, '0, 1'b1);
        idle(2);

        // Clear and qualified increment together.
        for (int k = 0; k < 5; k++) step(4'b0001, '0, '0, '0, 1'b0);
        step(4'b0001, 4'b0001, '0, '0, 1'b0);
        check("clear_beats_inc", 64'(cnt_w[0]), 64'd0);

        // Asynchronous reset mid-count and mid-snapshot.
        step('0, 4'b0100, '0, '0, 1'b0);
        for (int k = 0; k < 100; k++) step(4'b0100, '0, '0, '0, (k >= 98));
        check("pre_reset_cnt2", 64'(cnt_w[2]), 64'd100);
        do_reset();
        for (int k = 0; k < 5; k++) step(4'b0100, '0, '0, '0, 1'b0);
        check("post_reset_cnt2", 64'(cnt_w[2]), 64'd5);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            e = 4'($urandom_range(0, 15));
            m = 4'($urandom_range(0, 15));
            v = 4'($urandom_range(0, 15));
            c = '0;
            if ($urandom_range(0, 11) == 0) c[$urandom_range(0, NCH - 1)] = 1'b1;
            step(e, c, m, v, ($urandom_range(0, 4) == 0));
        end
        idle(1);

        @(negedge clk);
        #1;
        check("sb_drained_end", 64'(sb_q.size()), 64'd0);
        check("snap_drained_end", 64'(snq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/metrics_counter_bank.md
METRICS_COUNTER_BANK -- requirements
Module: metrics_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of independent counter channels (1..32).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 64, bits per counter (8..64).
REQ-003 SHALL have parameter SATURATE, default 1'b0, with 0 meaning wrap at overflow and 1 meaning hold at all-ones.
REQ-004 SHALL have clock port clk, input, 1, the single clock; all state is on its rising edge.
REQ-005 SHALL have reset port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port en, input, NUM_CHANNELS, per-channel count enable.
REQ-007 SHALL have port clear, input, NUM_CHANNELS, per-channel synchronous clear of counter and overflow flag.
REQ-008 SHALL have port mode, input, NUM_CHANNELS, per-channel source: 0 = cycles, 1 = events.
REQ-009 SHALL have port evt, input, NUM_CHANNELS, per-channel single-cycle event strobes.
REQ-010 SHALL have port snapshot, input, 1, global capture request.
REQ-011 SHALL have port cnt, output, NUM_CHANNELS x COUNTER_WIDTH, live counter values.
REQ-012 SHALL have port snap, output, NUM_CHANNELS x COUNTER_WIDTH, captured counter values.
REQ-013 SHALL have port snap_valid, output, 1, one-cycle pulse marking a fresh snap.
REQ-014 SHALL have port ovf, output, NUM_CHANNELS, sticky per-channel overflow flags.

Function
REQ-015 Channel i SHALL increment by exactly 1 on a rising edge when en[i]=1 and either mode[i]=0 or evt[i]=1.
REQ-016 cnt SHALL be registered, so an increment qualified in cycle N is visible on cnt in cycle N+1.
REQ-017 clear[i] SHALL take priority over increment: clear and a qualified increment in the same cycle leave cnt[i]=0 (not 1) and ovf[i]=0 in the next cycle.
REQ-018 With SATURATE=0, an increment from all-ones SHALL produce 0 and set ovf[i].
REQ-019 With SATURATE=1, an increment from all-ones SHALL hold all-ones and set ovf[i]; further increments SHALL leave the value unchanged.
REQ-020 ovf[i] SHALL stay set until clear[i] or rst.
REQ-021 When en[i]=0, the channel SHALL hold its value regardless of mode or evt.
REQ-022 snapshot=1 in cycle N SHALL load every snap[i] with the cnt[i] value present in cycle N (before that edge's update), and SHALL pulse snap_valid in cycle N+1 only.
REQ-023 snapshot and clear[i] in the same cycle SHALL capture the pre-clear value into snap[i].
REQ-024 snapshot held high for K cycles SHALL capture every cycle and hold snap_valid high for K cycles.
REQ-025 snap SHALL hold its last captured value between snapshots.
REQ-026 Channels SHALL be fully independent; no input of channel i affects channel j≠i.

Reset
REQ-027 On assertion of rst, cnt, snap, snap_valid and ovf SHALL go to 0 immediately, without waiting for a clock edge.
REQ-028 rst asserted mid-count or mid-snapshot SHALL discard all state; the first increment after deassertion yields cnt=1 one cycle later.

Structure
REQ-029 Package metrics_pkg SHALL hold the count_mode_e enum (CNT_CYCLES=0, CNT_EVENTS=1) and constants MAX_CHANNELS=32 and MAX_COUNTER_WIDTH=64.
REQ-030 One sub-module, metrics_counter_channel, SHALL implement a single counter, its overflow flag and its snapshot register; the bank SHALL instantiate NUM_CHANNELS copies via generate and SHALL own snap_valid.
REQ-031 Elaboration SHALL fail if NUM_CHANNELS or COUNTER_WIDTH is outside the ranges in REQ-001 and REQ-002.

Verification
REQ-032 Cycle mode: NUM_CHANNELS=4, ch0 en=1 mode=0 for 10 cycles -> cnt[0]=10, other channels 0, ovf=0.
REQ-033 Event mode: ch1 en=1 mode=1, evt[1] pulsed 3 times over 20 cycles -> cnt[1]=3; then en=0 plus 2 pulses -> cnt[1] still 3.
REQ-034 Wrap: COUNTER_WIDTH=8, SATURATE=0, 257 cycles counted -> cnt=1, ovf=1; clear -> cnt=0, ovf=0 next cycle.
REQ-035 Saturate: COUNTER_WIDTH=8, SATURATE=1, 300 cycles counted -> cnt=255, ovf=1.
REQ-036 Snapshot with clear: cnt[0]=42, snapshot and clear[0] in the same cycle -> snap[0]=42, snap_valid pulses for 1 cycle, cnt[0]=0.
REQ-037 Async reset: rst asserted between clock edges with cnt[2]=100 -> all outputs 0 before the next edge; after release, 5 cycles counted -> cnt[2]=5.
